// File: rtl/color_bbox_detect.sv
// Colour-window detector: pops filtered RGB565 pixels, emits a per-pixel mask
// and publishes the hit count and bounding box of hit pixels at each frame end.
module color_bbox_detect #(
    parameter int LINE_LENGTH = 480,
    parameter int LINE_COUNT  = 480,
    localparam int XW = $clog2(LINE_LENGTH),
    localparam int YW = $clog2(LINE_COUNT),
    localparam int CW = $clog2(LINE_LENGTH * LINE_COUNT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic          i_flush,
    input  logic [15:0]   i_data,
    input  logic          i_empty,
    output logic          o_rd,
    input  logic [4:0]    i_r_min,
    input  logic [4:0]    i_r_max,
    input  logic [5:0]    i_g_min,
    input  logic [5:0]    i_g_max,
    input  logic [4:0]    i_b_min,
    input  logic [4:0]    i_b_max,
    output logic          o_mask_valid,
    output logic          o_mask,
    output logic          o_frame_done,
    output logic          o_found,
    output logic [CW-1:0] o_hit_count,
    output logic [XW-1:0] o_x_min,
    output logic [XW-1:0] o_x_max,
    output logic [YW-1:0] o_y_min,
    output logic [YW-1:0] o_y_max
);

    localparam logic [XW-1:0] X_LAST = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINE_COUNT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic          rd, rd_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last, y_last;

    logic          p1_valid, p1_last;
    logic [15:0]   p1_data;
    logic [XW-1:0] p1_x;
    logic [YW-1:0] p1_y;

    logic [4:0]    r, b;
    logic [5:0]    g;
    logic          in_window, hit, frame_end;

    logic [CW-1:0] cnt, cnt_next;
    logic [XW-1:0] acc_x_min, acc_x_max, acc_x_min_next, acc_x_max_next;
    logic [YW-1:0] acc_y_min, acc_y_max, acc_y_min_next, acc_y_max_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_enable)  state_next = RUN;
            RUN:     if (!i_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        rd = i_enable & ~i_empty & ~i_flush & ~i_rst;
    end

    assign o_rd   = rd;
    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_q     <= 1'b0;
            p1_valid <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            rd_q     <= rd;
            p1_valid <= rd_q;
            if (rd_q) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; p1_valid qualifies them.
    always_ff @(posedge i_clk) begin
        if (rd_q) begin
            p1_data <= i_data;
            p1_x    <= x;
            p1_y    <= y;
            p1_last <= x_last & y_last;
        end
    end

    assign {r, g, b}    = p1_data;
    assign in_window    = (r >= i_r_min) && (r <= i_r_max) &&
                          (g >= i_g_min) && (g <= i_g_max) &&
                          (b >= i_b_min) && (b <= i_b_max);
    assign hit          = p1_valid & ~i_flush & in_window;
    assign frame_end    = p1_valid & ~i_flush & p1_last;
    assign o_mask_valid = p1_valid & ~i_flush;
    assign o_mask       = hit;

    always_comb begin
        cnt_next       = cnt;
        acc_x_min_next = acc_x_min;
        acc_x_max_next = acc_x_max;
        acc_y_min_next = acc_y_min;
        acc_y_max_next = acc_y_max;
        if (hit) begin
            cnt_next = cnt + CW'(1);
            if (p1_x < acc_x_min) acc_x_min_next = p1_x;
            if (p1_x > acc_x_max) acc_x_max_next = p1_x;
            if (p1_y < acc_y_min) acc_y_min_next = p1_y;
            if (p1_y > acc_y_max) acc_y_max_next = p1_y;
        end
    end

    // Flush clears the running frame but keeps the last published result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt          <= '0;
            acc_x_min    <= '1;
            acc_x_max    <= '0;
            acc_y_min    <= '1;
            acc_y_max    <= '0;
            o_frame_done <= 1'b0;
            o_found      <= 1'b0;
            o_hit_count  <= '0;
            o_x_min      <= '0;
            o_x_max      <= '0;
            o_y_min      <= '0;
            o_y_max      <= '0;
        end else if (i_flush || frame_end) begin
            cnt          <= '0;
            acc_x_min    <= '1;
            acc_x_max    <= '0;
            acc_y_min    <= '1;
            acc_y_max    <= '0;
            o_frame_done <= frame_end;
            if (frame_end) begin
                o_hit_count <= cnt_next;
                o_found     <= (cnt_next != '0);
                o_x_min     <= (cnt_next != '0) ? acc_x_min_next : '0;
                o_x_max     <= (cnt_next != '0) ? acc_x_max_next : '0;
                o_y_min     <= (cnt_next != '0) ? acc_y_min_next : '0;
                o_y_max     <= (cnt_next != '0) ? acc_y_max_next : '0;
            end
        end else begin
            cnt          <= cnt_next;
            acc_x_min    <= acc_x_min_next;
            acc_x_max    <= acc_x_max_next;
            acc_y_min    <= acc_y_min_next;
            acc_y_max    <= acc_y_max_next;
            o_frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_color_bbox_detect.sv
// Directed bench for color_bbox_detect on an 8x4 frame with an in-bench
// upstream buffer model and hand-computed frame results.
module tb_color_bbox_detect;

    localparam int LL = 8;
    localparam int LC = 4;

    logic        i_clk, i_rst, i_enable, i_flush, i_empty, o_rd;
    logic [15:0] i_data;
    logic [4:0]  i_r_min, i_r_max, i_b_min, i_b_max;
    logic [5:0]  i_g_min, i_g_max;
    logic        o_mask_valid, o_mask, o_frame_done, o_found;
    logic [5:0]  o_hit_count;
    logic [2:0]  o_x_min, o_x_max;
    logic [1:0]  o_y_min, o_y_max;

    color_bbox_detect #(.LINE_LENGTH(LL), .LINE_COUNT(LC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_data(i_data), .i_empty(i_empty), .o_rd(o_rd),
        .i_r_min(i_r_min), .i_r_max(i_r_max), .i_g_min(i_g_min), .i_g_max(i_g_max),
        .i_b_min(i_b_min), .i_b_max(i_b_max),
        .o_mask_valid(o_mask_valid), .o_mask(o_mask), .o_frame_done(o_frame_done),
        .o_found(o_found), .o_hit_count(o_hit_count),
        .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max)
    );

    int asserts  = 0;
    int failures = 0;

    int cyc = 0;
    int mask_total = 0, mask_ones = 0, mask_run = 0, last_mask_cyc = -10;
    int last_rd_cyc = 0, rd_while_empty = 0;
    logic [16:0] done_res[$];
    int          done_cyc[$];
    logic [15:0] pix_q[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [16:0] res();
        return {o_found, o_hit_count, o_x_min, o_x_max, o_y_min, o_y_max};
    endfunction

    always @(negedge i_clk) begin
        if (o_mask_valid === 1'b1) begin
            mask_total++;
            if (o_mask === 1'b1) mask_ones++;
            mask_run = (last_mask_cyc == cyc - 1) ? mask_run + 1 : 1;
            last_mask_cyc = cyc;
        end
        if (o_rd === 1'b1) begin
            last_rd_cyc = cyc;
            if (i_empty) rd_while_empty++;
        end
        if (o_frame_done === 1'b1) begin
            done_res.push_back(res());
            done_cyc.push_back(cyc);
        end
    end

    // Pixel idx = y*8 + x; red is 31 at the listed indices, base_r elsewhere.
    task automatic push_pixels(input int n, input logic [4:0] base_r, input int h0, input int h1, input int h2);
        for (int i = 0; i < n; i++) begin
            logic [4:0] rr;
            rr = (i == h0 || i == h1 || i == h2) ? 5'd31 : base_r;
            pix_q.push_back({rr, 6'(i * 3), 5'(i)});
        end
    endtask

    task automatic set_window(input logic [4:0] rmin, input logic [4:0] rmax);
        i_r_min = rmin; i_r_max = rmax;
        i_g_min = 6'd0; i_g_max = 6'd63;
        i_b_min = 5'd0; i_b_max = 5'd31;
    endtask

    // Upstream buffer model; entered and left at posedge+1.
    task automatic stream(input bit stalls, input int flush_at, input int stop_at);
        bit rd_now;
        bit flushed = 1'b0;
        int pops = 0;
        int guard = 0;
        while (pix_q.size() != 0 && pops != stop_at && guard < 3000) begin
            guard++;
            i_flush = 1'b0;
            if (pops == flush_at && !flushed) begin
                i_flush = 1'b1; i_enable = 1'b1; i_empty = 1'b0;
                #1;
                asserts++;
                if (o_rd !== 1'b0) begin failures++; $display("FAIL flush_rd: got %b expected 0", o_rd); end
                asserts++;
                if (o_mask_valid !== 1'b0) begin failures++; $display("FAIL flush_mask_valid: got %b expected 0", o_mask_valid); end
                rd_now  = 1'b0;
                flushed = 1'b1;
            end else begin
                i_enable = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
                i_empty  = stalls ? ($urandom_range(0, 4) == 0) : 1'b0;
                #1 rd_now = o_rd;
            end
            @(posedge i_clk); #1;
            if (rd_now) begin
                i_data = pix_q.pop_front();
                pops++;
            end else begin
                i_data = 16'hFFFF;
            end
        end
        i_flush = 1'b0;
        asserts++;
        if (guard >= 3000) begin failures++; $display("FAIL stream_budget: got %0d cycles expected < 3000", guard); end
        if (stop_at < 0) begin
            i_empty = 1'b1;
            repeat (6) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_enable = 1'b1; i_empty = 1'b0; i_flush = 1'b0; i_data = 16'hFFFF;
        set_window(5'd0, 5'd31);
        #1;
        asserts++;
        if (o_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b expected 0", o_rd); end
        repeat (2) @(posedge i_clk);
        #1;
        asserts++;
        if (res() !== 17'h0) begin failures++; $display("FAIL reset_results: got %h expected 0", res()); end
        asserts++;
        if ({o_mask_valid, o_mask, o_frame_done} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {o_mask_valid, o_mask, o_frame_done});
        end
        i_rst = 1'b0; i_enable = 1'b0; i_empty = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_full_window();
        int mt = mask_total, mo = mask_ones, d0 = done_res.size();
        set_window(5'd0, 5'd31);
        push_pixels(32, 5'd3, -1, -1, -1);
        stream(1'b0, -1, -1);
        asserts++;
        if (mask_ones - mo !== 32 || mask_total - mt !== 32) begin
            failures++; $display("FAIL full_mask_count: got %0d/%0d expected 32/32", mask_ones - mo, mask_total - mt);
        end
        asserts++;
        if (mask_run !== 32) begin failures++; $display("FAIL full_mask_consecutive: got %0d expected 32", mask_run); end
        asserts++;
        if (done_res.size() - d0 !== 1) begin
            failures++; $display("FAIL full_done_count: got %0d expected 1", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== {1'b1, 6'd32, 3'd0, 3'd7, 2'd0, 2'd3}) begin
                failures++; $display("FAIL full_result: got %h expected %h", done_res[d0], {1'b1, 6'd32, 3'd0, 3'd7, 2'd0, 2'd3});
            end
            asserts++;
            if (done_cyc[d0] - last_rd_cyc !== 3) begin
                failures++; $display("FAIL full_done_latency: got %0d expected 3", done_cyc[d0] - last_rd_cyc);
            end
        end
    endtask

    task automatic test_sparse(input bit stalls);
        int mt = mask_total, mo = mask_ones, d0 = done_res.size(), re = rd_while_empty;
        set_window(5'd31, 5'd31);
        push_pixels(32, 5'd30, 10, 13, 19);
        stream(stalls, -1, -1);
        asserts++;
        if (mask_ones - mo !== 3 || mask_total - mt !== 32) begin
            failures++; $display("FAIL sparse_mask_count: got %0d/%0d expected 3/32", mask_ones - mo, mask_total - mt);
        end
        asserts++;
        if (done_res.size() - d0 !== 1) begin
            failures++; $display("FAIL sparse_done_count: got %0d expected 1", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== {1'b1, 6'd3, 3'd2, 3'd5, 2'd1, 2'd2}) begin
                failures++; $display("FAIL sparse_result: got %h expected %h", done_res[d0], {1'b1, 6'd3, 3'd2, 3'd5, 2'd1, 2'd2});
            end
        end
        if (stalls) begin
            asserts++;
            if (rd_while_empty - re !== 0) begin
                failures++; $display("FAIL stall_rd_while_empty: got %0d expected 0", rd_while_empty - re);
            end
        end
    endtask

    task automatic test_back_to_back();
        int mt = mask_total, d0 = done_res.size();
        set_window(5'd31, 5'd31);
        push_pixels(32, 5'd30, 31, -1, -1);
        push_pixels(32, 5'd30, 0, 20, -1);
        stream(1'b0, -1, -1);
        asserts++;
        if (mask_total - mt !== 64) begin failures++; $display("FAIL b2b_mask_total: got %0d expected 64", mask_total - mt); end
        asserts++;
        if (done_res.size() - d0 !== 2) begin
            failures++; $display("FAIL b2b_done_count: got %0d expected 2", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== {1'b1, 6'd1, 3'd7, 3'd7, 2'd3, 2'd3}) begin
                failures++; $display("FAIL b2b_frame1: got %h expected %h", done_res[d0], {1'b1, 6'd1, 3'd7, 3'd7, 2'd3, 2'd3});
            end
            asserts++;
            if (done_res[d0+1] !== {1'b1, 6'd2, 3'd0, 3'd4, 2'd0, 2'd2}) begin
                failures++; $display("FAIL b2b_frame2: got %h expected %h", done_res[d0+1], {1'b1, 6'd2, 3'd0, 3'd4, 2'd0, 2'd2});
            end
            asserts++;
            if (done_cyc[d0+1] - done_cyc[d0] !== 32) begin
                failures++; $display("FAIL b2b_spacing: got %0d expected 32", done_cyc[d0+1] - done_cyc[d0]);
            end
        end
    endtask

    task automatic test_flush();
        int d0 = done_res.size();
        logic [16:0] held = {1'b1, 6'd3, 3'd2, 3'd5, 2'd1, 2'd2};
        set_window(5'd31, 5'd31);
        push_pixels(13, 5'd30, 5, 20, -1);
        push_pixels(32, 5'd30, 9, 30, -1);
        stream(1'b0, 13, 29);
        asserts++;
        if (res() !== held) begin failures++; $display("FAIL flush_held: got %h expected %h", res(), held); end
        asserts++;
        if (done_res.size() - d0 !== 0) begin
            failures++; $display("FAIL flush_no_done: got %0d expected 0", done_res.size() - d0);
        end
        stream(1'b0, -1, -1);
        asserts++;
        if (done_res.size() - d0 !== 1) begin
            failures++; $display("FAIL flush_done_count: got %0d expected 1", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== {1'b1, 6'd2, 3'd1, 3'd6, 2'd1, 2'd3}) begin
                failures++; $display("FAIL flush_result: got %h expected %h", done_res[d0], {1'b1, 6'd2, 3'd1, 3'd6, 2'd1, 2'd3});
            end
        end
    endtask

    task automatic test_empty_window();
        int mt = mask_total, mo = mask_ones, d0 = done_res.size();
        set_window(5'd20, 5'd10);
        push_pixels(32, 5'd15, -1, -1, -1);
        stream(1'b0, -1, -1);
        asserts++;
        if (mask_ones - mo !== 0 || mask_total - mt !== 32) begin
            failures++; $display("FAIL empty_mask_count: got %0d/%0d expected 0/32", mask_ones - mo, mask_total - mt);
        end
        asserts++;
        if (done_res.size() - d0 !== 1) begin
            failures++; $display("FAIL empty_done_count: got %0d expected 1", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== 17'h0) begin failures++; $display("FAIL empty_result: got %h expected 0", done_res[d0]); end
        end
    endtask

    task automatic test_midframe_reset();
        int d0;
        set_window(5'd0, 5'd31);
        push_pixels(32, 5'd3, -1, -1, -1);
        push_pixels(10, 5'd3, -1, -1, -1);
        stream(1'b0, -1, 42);
        asserts++;
        if (o_hit_count !== 6'd32) begin failures++; $display("FAIL prereset_count: got %0d expected 32", o_hit_count); end
        i_rst = 1'b1;
        #1;
        asserts++;
        if (o_rd !== 1'b0) begin failures++; $display("FAIL midreset_rd: got %b expected 0", o_rd); end
        @(posedge i_clk); #1;
        asserts++;
        if (res() !== 17'h0) begin failures++; $display("FAIL midreset_results: got %h expected 0", res()); end
        asserts++;
        if ({o_mask_valid, o_frame_done} !== 2'b00) begin
            failures++; $display("FAIL midreset_flags: got %b expected 00", {o_mask_valid, o_frame_done});
        end
        i_rst = 1'b0;
        pix_q.delete();
        d0 = done_res.size();
        push_pixels(32, 5'd3, -1, -1, -1);
        stream(1'b0, -1, -1);
        asserts++;
        if (done_res.size() - d0 !== 1) begin
            failures++; $display("FAIL postreset_done_count: got %0d expected 1", done_res.size() - d0);
        end else begin
            asserts++;
            if (done_res[d0] !== {1'b1, 6'd32, 3'd0, 3'd7, 2'd0, 2'd3}) begin
                failures++; $display("FAIL postreset_result: got %h expected %h", done_res[d0], {1'b1, 6'd32, 3'd0, 3'd7, 2'd0, 2'd3});
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_sparse(1'b0);
        test_back_to_back();
        test_sparse(1'b1);
        test_flush();
        test_empty_window();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
